// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed seven-segment scan controller
// Double-buffered N-digit hex display with guard blanking and leading-zero suppression.
module display_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [4*N_DIG-1:0]   valor_in,
  input  logic                 load,
  output logic                 busy,
  output logic                 ack,
  input  logic                 blank_lz,
  output logic [3:0]           dec_in,
  input  logic [6:0]           dec_out,
  output logic [6:0]           seg,
  output logic [N_DIG-1:0]     an
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N_DIG);

  logic [PW-1:0]        presc_q, presc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*N_DIG-1:0]   active_q, active_d;
  logic [4*N_DIG-1:0]   shadow_q, shadow_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic [6:0]           seg_q, seg_d;
  logic [N_DIG-1:0]     an_q, an_d;

  logic tick;
  logic frame_end;
  logic nz_above;
  logic blank_d;

  assign tick      = (presc_q == PW'(DIV - 1));
  assign frame_end = tick && (idx_q == IW'(N_DIG - 1));
  assign dec_in    = active_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
    end

    // A pending shadow blocks new loads until it is committed on a frame boundary.
    active_d = active_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    if (busy_q) begin
      if (frame_end) begin
        active_d = shadow_q;
        busy_d   = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (load) begin
      shadow_d = valor_in;
      busy_d   = 1'b1;
    end

    nz_above = 1'b0;
    for (int j = 0; j < N_DIG; j++) begin
      if ((j >= int'(idx_q)) && (active_q[4*j +: 4] != 4'h0)) begin
        nz_above = 1'b1;
      end
    end
    blank_d = blank_lz && (idx_q != '0) && !nz_above;

    seg_d = blank_d ? 7'h7F : dec_out;
    an_d  = (presc_q < PW'(GUARD)) ? '1 : ~(N_DIG'(1) << idx_q);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc_q  <= '0;
      idx_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy = busy_q;
  assign ack  = ack_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl
// Cycle-indexed reference with a queue of pending loads and their expected ack cycles.
module tb_display_scan_ctrl;

  logic        Clock;
  logic        Resetn;
  logic [15:0] valor_in;
  logic        load;
  logic        busy;
  logic        ack;
  logic        blank_lz;
  logic [3:0]  dec_in;
  logic [6:0]  dec_out;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_vec;
  int n_bad;

  display_scan_ctrl #(.N_DIG(4), .DIV(8), .GUARD(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .valor_in(valor_in), .load(load),
    .busy(busy), .ack(ack), .blank_lz(blank_lz), .dec_in(dec_in),
    .dec_out(dec_out), .seg(seg), .an(an)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign dec_out = hex7(dec_in);

  typedef struct {
    logic [15:0] val;
    int          ack_k;
  } pend_t;

  pend_t       sb[$];
  int          k;
  logic [15:0] disp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_ack;
  logic        exp_busy;

  // One clock: record accepted loads, then derive expected outputs for the edge just taken.
  task automatic step();
    logic       bl;
    pend_t      p;
    int         pr;
    int         ix;
    logic [3:0] nib;
    logic [15:0] upper;
    bl = blank_lz;
    if (load && sb.size() == 0) begin
      p.val   = valor_in;
      p.ack_k = ((k + 1) / 32) * 32 + 31;
      sb.push_back(p);
    end
    @(posedge Clock);
    #1;
    pr     = k % 8;
    ix     = (k / 8) % 4;
    exp_an = (pr < 2) ? 4'hF : ~(4'b0001 << ix);
    upper  = disp >> (4 * ix);
    nib    = upper[3:0];
    exp_seg = (bl && ix != 0 && upper == 16'h0) ? 7'h7F : hex7(nib);
    exp_ack = 1'b0;
    if (sb.size() != 0 && sb[0].ack_k == k) begin
      exp_ack = 1'b1;
      disp    = sb[0].val;
      void'(sb.pop_front());
    end
    exp_busy = (sb.size() != 0);
    k++;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; load = 1'b0; valor_in = 16'h0; blank_lz = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_vec++; if (an !== 4'hF)   begin n_bad++; $display("FAIL reset_an got %h exp f", an); end
    n_vec++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h exp 7f", seg); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (ack !== 1'b0)  begin n_bad++; $display("FAIL reset_ack got %b exp 0", ack); end
    Resetn = 1'b1;
    k = 0; disp = 16'h0; sb.delete();
  endtask

  task automatic test_load_1234();
    int ack_at;
    ack_at = -1;
    valor_in = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy got %b exp 1", busy); end
    repeat (70) begin
      step();
      if (ack === 1'b1 && ack_at < 0) ack_at = k - 1;
      n_vec++; if (an !== exp_an)     begin n_bad++; $display("FAIL l1_an k=%0d got %h exp %h", k-1, an, exp_an); end
      n_vec++; if (seg !== exp_seg)   begin n_bad++; $display("FAIL l1_seg k=%0d got %h exp %h", k-1, seg, exp_seg); end
      n_vec++; if (ack !== exp_ack)   begin n_bad++; $display("FAIL l1_ack k=%0d got %b exp %b", k-1, ack, exp_ack); end
      n_vec++; if (busy !== exp_busy) begin n_bad++; $display("FAIL l1_busy k=%0d got %b exp %b", k-1, busy, exp_busy); end
    end
    n_vec++; if (ack_at != 31) begin n_bad++; $display("FAIL l1_ack_cycle got %0d exp 31", ack_at); end
  endtask

  task automatic test_guard();
    repeat (64) begin
      step();
      n_vec++; if (an !== exp_an) begin n_bad++; $display("FAIL guard_an k=%0d got %h exp %h", k-1, an, exp_an); end
      n_vec++; if ($countones(~an) > 1) begin n_bad++; $display("FAIL guard_onehot k=%0d got %h exp <=1 low", k-1, an); end
    end
  endtask

  task automatic test_blank_lz();
    logic [15:0] vals [2];
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      valor_in = vals[v]; load = 1'b1;
      step();
      load = 1'b0;
      repeat (75) begin
        step();
        n_vec++; if (an !== exp_an)   begin n_bad++; $display("FAIL lz_an k=%0d got %h exp %h", k-1, an, exp_an); end
        n_vec++; if (seg !== exp_seg) begin n_bad++; $display("FAIL lz_seg k=%0d got %h exp %h", k-1, seg, exp_seg); end
        n_vec++; if (ack !== exp_ack) begin n_bad++; $display("FAIL lz_ack k=%0d got %b exp %b", k-1, ack, exp_ack); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    valor_in = 16'hAAAA; load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    valor_in = 16'hBBBB; load = 1'b1;
    step();
    load = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b exp 1", busy); end
    for (int c = 0; c < 130; c++) begin
      if (!exp_busy && c > 20 && c < 40) begin valor_in = 16'hCCCC; load = 1'b1; end
      else load = 1'b0;
      step();
      n_vec++; if (seg !== exp_seg)   begin n_bad++; $display("FAIL b2b_seg k=%0d got %h exp %h", k-1, seg, exp_seg); end
      n_vec++; if (ack !== exp_ack)   begin n_bad++; $display("FAIL b2b_ack k=%0d got %b exp %b", k-1, ack, exp_ack); end
      n_vec++; if (busy !== exp_busy) begin n_bad++; $display("FAIL b2b_busy k=%0d got %b exp %b", k-1, busy, exp_busy); end
    end
    load = 1'b0;
    n_vec++; if (disp !== 16'hCCCC) begin n_bad++; $display("FAIL b2b_final got %h exp cccc", disp); end
  endtask

  task automatic test_boundary_load();
    int cap;
    int ack_at;
    ack_at = -1;
    repeat (40) if (k % 32 != 31 || sb.size() != 0) step();
    valor_in = 16'h9876; load = 1'b1;
    cap = k;
    step();
    load = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bnd_busy got %b exp 1", busy); end
    repeat (80) begin
      step();
      if (ack === 1'b1 && ack_at < 0) ack_at = k - 1;
      n_vec++; if (seg !== exp_seg) begin n_bad++; $display("FAIL bnd_seg k=%0d got %h exp %h", k-1, seg, exp_seg); end
      n_vec++; if (ack !== exp_ack) begin n_bad++; $display("FAIL bnd_ack k=%0d got %b exp %b", k-1, ack, exp_ack); end
    end
    n_vec++; if (ack_at - cap != 32) begin n_bad++; $display("FAIL bnd_latency got %0d exp 32", ack_at - cap); end
  endtask

  task automatic test_reset_mid();
    valor_in = 16'h5A5A; load = 1'b1;
    repeat (3) step();
    load = 1'b0;
    repeat (10) step();
    #2;
    Resetn = 1'b0;
    #1;
    n_vec++; if (an !== 4'hF)   begin n_bad++; $display("FAIL rmid_an got %h exp f", an); end
    n_vec++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL rmid_seg got %h exp 7f", seg); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b exp 0", busy); end
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    k = 0; disp = 16'h0; sb.delete();
    repeat (70) begin
      step();
      n_vec++; if (an !== exp_an)   begin n_bad++; $display("FAIL rpost_an k=%0d got %h exp %h", k-1, an, exp_an); end
      n_vec++; if (seg !== exp_seg) begin n_bad++; $display("FAIL rpost_seg k=%0d got %h exp %h", k-1, seg, exp_seg); end
      n_vec++; if (ack !== 1'b0)    begin n_bad++; $display("FAIL rpost_ack k=%0d got %b exp 0", k-1, ack); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_load_1234();
    test_guard();
    test_blank_lz();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
